// File: rtl/clock_display_scanner_if.sv
// Display-side bundle for clock_display_scanner. It carries the BCD time,
// the alarm flag and enable toward the scanner, and the multiplexed
// seven-segment drive back out.
interface clock_display_scanner_if;
    logic       ena;    // display enable; 0 blanks every digit
    logic [7:0] hh;     // hours, BCD {tens,ones}
    logic [7:0] mm;     // minutes, BCD {tens,ones}
    logic [7:0] ss;     // seconds, BCD {tens,ones}
    logic       alarm;  // alarm active, drives the blink
    logic [6:0] seg;    // segments {g,f,e,d,c,b,a}
    logic       dp;     // decimal point
    logic [5:0] an;     // digit select, an[0] = seconds ones

    // Clock core / test side: drives time and control, observes the drive.
    modport master (
        output ena, hh, mm, ss, alarm,
        input  seg, dp, an
    );

    // Scanner side: consumes time and control, produces the display drive.
    modport slave (
        input  ena, hh, mm, ss, alarm,
        output seg, dp, an
    );
endinterface

// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed seven-segment scanner for the digital clock.
// Each digit is held for REFRESH_DIV cycles in the order ss ones, ss tens,
// mm ones, mm tens, hh ones, hh tens. The time is snapshotted once per scan
// frame so a frame never mixes two different times. While the alarm is
// active the whole display blinks with a half-period of BLINK_DIV cycles.
// Outputs are registered, one cycle behind the index/counter state.
module clock_display_scanner #(
    parameter int REFRESH_DIV = 1000,  // cycles per digit (min 2)
    parameter int BLINK_DIV   = 50000, // cycles per blink half-period (min 2)
    parameter bit ACTIVE_LOW  = 1'b1   // 1: seg/dp/an active-low
) (
    input  logic                    clk,
    input  logic                    reset,
    clock_display_scanner_if.slave  disp
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    // Inactive drive levels, used in reset and whenever a digit is off.
    localparam logic [5:0] AN_OFF  = ACTIVE_LOW ? 6'h3F : 6'h00;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    // Scan position; the encoding doubles as the an[] bit position.
    typedef enum logic [2:0] {
        DIG_SS_ONES = 3'd0,
        DIG_SS_TENS = 3'd1,
        DIG_MM_ONES = 3'd2,
        DIG_MM_TENS = 3'd3,
        DIG_HH_ONES = 3'd4,
        DIG_HH_TENS = 3'd5
    } digit_e;

    // ------------------------------------------------------------------
    // BCD nibble to active-high segments; non-decimal nibbles show a dash.
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [REF_W-1:0] refresh_cnt_q, refresh_cnt_d;
    digit_e           digit_q,       digit_d;
    logic [23:0]      snap_q,        snap_d;
    logic [BLK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic             blink_q,       blink_d;
    logic [5:0]       an_q,          an_d;
    logic [6:0]       seg_q,         seg_d;
    logic             dp_q,          dp_d;

    // Combinational helpers
    logic        refresh_wrap;
    logic        capture;
    logic [23:0] time_src;
    logic [3:0]  nibble;
    logic [5:0]  an_onehot;
    logic        dp_slot;
    logic        blank;

    // Refresh counter and digit sequencing: advance the digit on each wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned; a missing default would infer a latch.
        refresh_cnt_d = refresh_cnt_q + REF_W'(1);
        digit_d       = digit_q;
        refresh_wrap  = (refresh_cnt_q == REF_LAST);

        if (refresh_wrap) begin
            refresh_cnt_d = '0;
            case (digit_q)
                DIG_SS_ONES: digit_d = DIG_SS_TENS;
                DIG_SS_TENS: digit_d = DIG_MM_ONES;
                DIG_MM_ONES: digit_d = DIG_MM_TENS;
                DIG_MM_TENS: digit_d = DIG_HH_ONES;
                DIG_HH_ONES: digit_d = DIG_HH_TENS;
                default:     digit_d = DIG_SS_ONES;
            endcase
        end
    end

    // Frame snapshot: capture the live time at the start of every frame.
    always_comb begin
        capture  = (refresh_cnt_q == '0) && (digit_q == DIG_SS_ONES);
        snap_d   = snap_q;
        if (capture) begin
            snap_d = {disp.hh, disp.mm, disp.ss};
        end
        // In the capture cycle the snapshot register still holds the previous
        // frame, so decode straight from the value being captured.
        time_src = snap_d;
    end

    // Blink timer: runs only while the alarm is up, cleared otherwise.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (disp.alarm) begin
            blink_d = blink_q;
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Digit select, nibble pick and separator position for the current index.
    always_comb begin
        nibble    = time_src[3:0];
        an_onehot = 6'b00_0001;
        dp_slot   = 1'b0;
        case (digit_q)
            DIG_SS_ONES: begin
                nibble    = time_src[3:0];
                an_onehot = 6'b00_0001;
            end
            DIG_SS_TENS: begin
                nibble    = time_src[7:4];
                an_onehot = 6'b00_0010;
            end
            DIG_MM_ONES: begin
                nibble    = time_src[11:8];
                an_onehot = 6'b00_0100;
                dp_slot   = 1'b1;
            end
            DIG_MM_TENS: begin
                nibble    = time_src[15:12];
                an_onehot = 6'b00_1000;
            end
            DIG_HH_ONES: begin
                nibble    = time_src[19:16];
                an_onehot = 6'b01_0000;
                dp_slot   = 1'b1;
            end
            DIG_HH_TENS: begin
                nibble    = time_src[23:20];
                an_onehot = 6'b10_0000;
            end
            default: begin
                nibble    = time_src[3:0];
                an_onehot = 6'b00_0000;
            end
        endcase
    end

    // Output drive: blank on disable or blink-off phase, then apply polarity.
    always_comb begin
        // The blink phase only blanks while the alarm is still up, so dropping
        // the alarm restores the display on the very next registered output.
        blank = ~disp.ena | (disp.alarm & blink_q);
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (!blank) begin
            an_d  = ACTIVE_LOW ? ~an_onehot            : an_onehot;
            seg_d = ACTIVE_LOW ? ~seg_decode(nibble)   : seg_decode(nibble);
            dp_d  = ACTIVE_LOW ? ~dp_slot              : dp_slot;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            refresh_cnt_q <= '0;
            digit_q       <= DIG_SS_ONES;
            snap_q        <= 24'h0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_q       <= digit_d;
            snap_q        <= snap_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: doc/clock_display_scanner.md
Name: clock_display_scanner

Overview:
Downstream consumer of the digital clock core. Takes the BCD time outputs hh/mm/ss and the alarm flag, and drives a 6-digit multiplexed common-anode seven-segment display. It time-multiplexes the digits, snapshots the time once per scan frame so a frame never mixes two different times, and blinks the whole display while the alarm is active.

Parameters:
REFRESH_DIV, 1000, clk cycles each digit stays selected (min 2)
BLINK_DIV, 50000, clk cycles per blink half-period while alarm is high (min 2)
ACTIVE_LOW, 1, 1: seg/dp/an are active-low; 0: active-high

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
ena  in  1  display enable; 0 forces all digits off
hh  in  8  hours, BCD {tens,ones}
mm  in  8  minutes, BCD
ss  in  8  seconds, BCD
alarm  in  1  alarm active from clock core
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
an  out  6  digit select; an[0]=ss ones, an[1]=ss tens, an[2]=mm ones, an[3]=mm tens, an[4]=hh ones, an[5]=hh tens

Behaviour:
- Reset (synchronous, active-high): refresh counter=0, digit index=0, snapshot=24'h0, blink counter=0, blink phase=0. seg, dp and an are driven to the inactive level: all 1s if ACTIVE_LOW=1, all 0s otherwise.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. On the wrap, digit index increments; it goes 5 -> 0.
- Snapshot: {hh,mm,ss} is captured in the cycle where refresh counter==0 and index==0. This includes the first cycle after reset is released.
- Decode path bypasses the snapshot in the capture cycle. As a result, digit 0 of a frame always shows the newly captured value.
- Outputs are registered: an/seg/dp reflect the index and counter state of the previous cycle. Latency is 1 clk.
- an: exactly one digit is active, the one equal to the index. All digits are off when ena=0 or blink phase=1.
- seg encoding (active-high form; inverted when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A-F show a dash: 40.
- dp: active only on index 2 and index 4 (the mm/ss and hh/mm separators). Forced inactive whenever an is all off.
- Blink logic:
  - While alarm=1, the blink counter counts 0..BLINK_DIV-1. On each wrap the blink phase toggles.
  - Phase 0 = visible; phase 1 = blank.
  - When alarm=0, the blink counter and phase are cleared every cycle. The display is therefore visible immediately after alarm is released or stopped.
- ena=0: the refresh and blink counters keep running and the snapshot still updates. Only the outputs are blanked.
- Simultaneous events: reset dominates everything. Capture and index wrap in the same cycle is the normal 5 -> 0 case. An alarm edge coinciding with a refresh wrap has no interaction.
- Reset mid-frame: all state returns to reset values on the next edge. Scanning restarts at index 0 with a fresh capture.

Test Plan:
1. Reset -> check the outputs after the first edge with reset=1 (REFRESH_DIV=4, ACTIVE_LOW=1). Required: an=6'h3F, seg=7'h7F, dp=1.
2. Scan order, with hh=8'h12, mm=8'h34, ss=8'h56, ena=1, alarm=0, REFRESH_DIV=4. Required: starting 1 cycle after reset release, each digit is held 4 cycles in turn.
   - an sequence 3E,3D,3B,37,2F,1F, repeating.
   - seg (inverted) sequence 02,12,19,30,24,79.
   - dp=0 only during an=3B and an=2F.
3. Tearing check: change ss from 8'h59 to 8'h00 while index=3 -> digits 0/1 keep showing 9/5 until the next frame starts, then show 0/0.
4. Invalid BCD, with mm=8'hA7 -> the index-3 digit shows seg=7'h3F (inverted dash) and the index-2 digit shows 7.
5. Blink, with alarm=1 held and BLINK_DIV=8:
   - an is all 1s for cycles 9-16 after alarm rises, and normal scanning resumes at cycles 17-24.
   - Dropping alarm during the blank phase restores scanning on the next registered output.
6. ena=0 mid-scan -> an=3F and dp=1 one cycle later. Re-raising ena resumes at the current index; no restart to index 0.
